// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package instruction_fetch_queue_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam int         ENTRY_PC_W = 32;

    typedef struct packed {
        logic [31:0]           ins;
        logic [ENTRY_PC_W-1:0] pc;
        logic                  pred_taken;
        logic [ENTRY_PC_W-1:0] pred_target;
    } fetch_entry_t;

    // J-type immediate, sign-extended; only instruction bits [31:12] carry it.
    function automatic logic [31:0] imm_j(input logic [31:12] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_circ_queue.sv
// Generic DEPTH x WIDTH circular FIFO with clear; head data is read straight from storage.
module instruction_fetch_queue_circ_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_clear,
    input  logic [WIDTH-1:0]               i_wdata,
    output logic [WIDTH-1:0]               o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_wdata;
                r_tail        <= r_tail + PW'(1);
            end
            if (i_pop) r_head <= r_head + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Sequential instruction prefetcher with credit flow control, flush redirect and
// optional static JAL prediction; stale in-flight responses are counted off and dropped.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int              DEPTH           = 8,
    parameter int              XLEN            = 32,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter bit              PREDICT_JAL     = 1'b1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_pipeline,
    input  logic [XLEN-1:0]              flush_pc,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [XLEN-1:0]              mem_req_addr,
    input  logic                         mem_rsp_valid,
    input  logic [31:0]                  mem_rsp_data,
    output logic                         ins_valid,
    input  logic                         need_issue,
    output logic [31:0]                  ins_full,
    output logic [XLEN-1:0]              ins_pc,
    output logic                         ins_pred_taken,
    output logic [XLEN-1:0]              ins_pred_target,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(MAX_OUTSTANDING+1);

    logic            r_active;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [IW-1:0]   r_inflight;
    logic [IW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;
    logic            w_credit;
    logic            w_req_acc;
    logic            w_flush;
    logic            w_rsp_keep;
    logic            w_is_jal;
    logic            w_pop;
    logic [XLEN-1:0] w_jal_target;
    logic [XLEN-1:0] w_seq_target;
    logic [IW-1:0]   w_inflight_nxt;

    // Every accepted request reserves a queue slot, so a kept response never overflows.
    assign w_credit       = (int'(w_count) + int'(r_inflight) < DEPTH) &&
                            (int'(r_inflight) < MAX_OUTSTANDING);
    assign mem_req_valid  = rdy_in && r_active && w_credit;
    assign mem_req_addr   = r_fetch_pc;
    assign w_req_acc      = mem_req_valid && mem_req_ready;

    assign w_flush        = rdy_in && flush_pipeline;
    assign w_rsp_keep     = mem_rsp_valid && (r_drop == '0) && !w_flush;
    assign w_is_jal       = PREDICT_JAL && w_rsp_keep && (mem_rsp_data[6:0] == OPC_JAL);
    assign w_jal_target   = r_rsp_pc + XLEN'($signed(imm_j(mem_rsp_data[31:12])));
    assign w_seq_target   = r_rsp_pc + XLEN'(4);
    assign w_inflight_nxt = r_inflight + IW'(w_req_acc) - IW'(mem_rsp_valid);

    assign ins_valid      = rdy_in && (w_count != '0);
    assign w_pop          = ins_valid && need_issue && !w_flush;

    always_comb begin
        w_wdata             = '0;
        w_wdata.ins         = mem_rsp_data;
        w_wdata.pc          = ENTRY_PC_W'(r_rsp_pc);
        w_wdata.pred_taken  = w_is_jal;
        w_wdata.pred_target = ENTRY_PC_W'(w_is_jal ? w_jal_target : w_seq_target);
    end

    instruction_fetch_queue_circ_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_rsp_keep),
        .i_pop   (w_pop),
        .i_clear (w_flush),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= w_inflight_nxt;
            // Either redirect makes every response still outstanding after this cycle stale.
            if (w_flush) begin
                r_fetch_pc <= flush_pc;
                r_rsp_pc   <= flush_pc;
                r_drop     <= w_inflight_nxt;
            end else if (w_is_jal) begin
                r_fetch_pc <= w_jal_target;
                r_rsp_pc   <= w_jal_target;
                r_drop     <= w_inflight_nxt;
            end else begin
                if (w_req_acc) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_rsp_keep) r_rsp_pc <= w_seq_target;
                if (mem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - IW'(1);
            end
        end
    end

    assign ins_full        = w_head.ins;
    assign ins_pc          = XLEN'(w_head.pc);
    assign ins_pred_taken  = w_head.pred_taken;
    assign ins_pred_target = XLEN'(w_head.pred_target);
    assign count           = w_count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: a behavioural memory answers fetches
// in order, and issued entries are compared against a scoreboard of expected entries.
module tb_instruction_fetch_queue;

    localparam int          DEPTH   = 8;
    localparam int          XLEN    = 32;
    localparam int          MAXO    = 2;
    localparam logic [31:0] RPC     = 32'h0000_1000;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_100 = 32'h1000_006F;   // jal x0, +0x100

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_pipeline = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        need_issue = 1'b0;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        ins_valid;
    logic [31:0] ins_full;
    logic [31:0] ins_pc;
    logic        ins_pred_taken;
    logic [31:0] ins_pred_target;
    logic [3:0]  count;

    instruction_fetch_queue #(
        .DEPTH           (DEPTH),
        .XLEN            (XLEN),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC),
        .PREDICT_JAL     (1'b1)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush_pipeline  (flush_pipeline),
        .flush_pc        (flush_pc),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .ins_valid       (ins_valid),
        .need_issue      (need_issue),
        .ins_full        (ins_full),
        .ins_pc          (ins_pc),
        .ins_pred_taken  (ins_pred_taken),
        .ins_pred_target (ins_pred_target),
        .count           (count)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_err    = 0;

    // Memory model: requests seen on the negedge are accepted on the next posedge and
    // answered mem_lat cycles later, in order, unless mem_hold stalls the response path.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [31:0] imem [logic [31:0]];
    int          mem_lat  = 1;
    bit          mem_hold = 1'b0;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    int          max_pend = 0;

    function automatic logic [31:0] imem_read(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return NOP;
    endfunction

    always @(negedge clk_in) begin
        cyc++;
        if (!rst_in) begin
            pend.delete();
            mem_rsp_valid = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc && !mem_hold) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = imem_read(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                pend.push_back('{mem_req_addr, cyc + mem_lat});
                acc_cnt++;
                if (pend.size() > max_pend) max_pend = pend.size();
            end
        end
    end

    logic [96:0] sb[$];

    function automatic logic [96:0] mk(input logic [31:0] pc, input logic [31:0] ins,
                                       input logic taken, input logic [31:0] tgt);
        return {ins, pc, taken, tgt};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        int          w = 0;
        logic [96:0] e;
        logic [96:0] obs;
        while (ins_valid !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, ins_valid, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, sb.size(), 1);
        end else begin
            e   = sb.pop_front();
            obs = {ins_full, ins_pc, ins_pred_taken, ins_pred_target};
            chk(tag, obs, e);
        end
        need_issue = 1'b1;
        tick();
        need_issue = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_in = 1'b0;
        need_issue = 1'b0;
        flush_pipeline = 1'b0;
        rdy_in = 1'b1;
        mem_hold = 1'b0;
        mem_lat = 1;
        imem.delete();
        #1;
        chk("rst_async", {count, ins_valid, mem_req_valid}, '0);
        tick();
        tick();
        rst_in = 1'b1;
        #1;
    endtask

    initial begin
        int acc_base;
        int w;

        // reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_ins_valid", ins_valid, 1'b0);
        chk("rst_count", count, 4'd0);
        chk("rst_ins_full", ins_full, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'd0);
        chk("rst_pred_taken", ins_pred_taken, 1'b0);
        chk("rst_pred_target", ins_pred_target, 32'd0);
        chk("rst_req_addr", mem_req_addr, RPC);
        rst_in = 1'b1;
        #1;
        acc_base = acc_cnt;
        tick();
        chk("first_req_valid", mem_req_valid, 1'b1);
        chk("first_req_addr", mem_req_addr, RPC);

        // fill with no issue: credit stops at DEPTH
        repeat (30) tick();
        chk("fill_acc", acc_cnt - acc_base, 8);
        chk("fill_count", count, 4'd8);
        chk("fill_req_valid", mem_req_valid, 1'b0);
        for (int i = 0; i < 8; i++)
            sb.push_back(mk(RPC + 32'(4*i), NOP, 1'b0, RPC + 32'(4*i + 4)));
        pop_check("seq0");
        chk("req_after_pop", mem_req_valid, 1'b1);
        for (int i = 1; i < 8; i++) pop_check("seq");

        // JAL at 0x1008 with 0x100C fetched behind it
        do_reset();
        imem[32'h1008] = JAL_100;
        repeat (30) tick();
        sb.push_back(mk(32'h1000, NOP, 1'b0, 32'h1004));
        sb.push_back(mk(32'h1004, NOP, 1'b0, 32'h1008));
        sb.push_back(mk(32'h1008, JAL_100, 1'b1, 32'h1108));
        sb.push_back(mk(32'h1108, NOP, 1'b0, 32'h110C));
        sb.push_back(mk(32'h110C, NOP, 1'b0, 32'h1110));
        for (int i = 0; i < 5; i++) pop_check("jal");

        // flush with 5 queued and 2 in flight
        do_reset();
        acc_base = acc_cnt;
        w = 0;
        while (count !== 4'd5 && w < 40) begin
            tick();
            w++;
        end
        mem_hold = 1'b1;
        repeat (3) tick();
        chk("flush_pre_count", count, 4'd5);
        chk("flush_pre_acc", acc_cnt - acc_base, 7);
        flush_pipeline = 1'b1;
        flush_pc = 32'h2000;
        mem_hold = 1'b0;
        tick();
        flush_pipeline = 1'b0;
        chk("flush_count", count, 4'd0);
        chk("flush_ins_valid", ins_valid, 1'b0);
        chk("flush_req_addr", mem_req_addr, 32'h2000);
        sb.push_back(mk(32'h2000, NOP, 1'b0, 32'h2004));
        sb.push_back(mk(32'h2004, NOP, 1'b0, 32'h2008));
        pop_check("flush_new");
        pop_check("flush_new");

        // rdy_in low while a response lands
        do_reset();
        acc_base = acc_cnt;
        tick();
        tick();
        rdy_in = 1'b0;
        need_issue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_ins_valid", ins_valid, 1'b0);
            chk("stall_req_valid", mem_req_valid, 1'b0);
        end
        chk("stall_count", count, 4'd1);
        chk("stall_acc", acc_cnt - acc_base, 1);
        need_issue = 1'b0;
        rdy_in = 1'b1;
        sb.push_back(mk(RPC, NOP, 1'b0, RPC + 32'd4));
        pop_check("stall_issue");

        // flush coinciding with a JAL response and a pop
        do_reset();
        imem[32'h1008] = JAL_100;
        repeat (4) tick();
        chk("combo_pre_count", count, 4'd2);
        flush_pipeline = 1'b1;
        flush_pc = 32'h3000;
        need_issue = 1'b1;
        tick();
        flush_pipeline = 1'b0;
        need_issue = 1'b0;
        chk("combo_count", count, 4'd0);
        chk("combo_req_addr", mem_req_addr, 32'h3000);
        sb.push_back(mk(32'h3000, NOP, 1'b0, 32'h3004));
        pop_check("combo_new");

        chk("max_inflight_ok", (max_pend <= MAXO), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
